// File: rtl/strip_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : strip_frame_scheduler_pkg
// Purpose  : State encoding, bank indices and default 50 MHz timing constants
// Revision : 1.0 - initial release
// ============================================================================
package strip_frame_scheduler_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic c_wr_bank_rst = 1'b0;
    localparam logic c_rd_bank_rst = 1'b1;

    localparam int c_refresh_cycles = 1666667;
    localparam int c_timeout_cycles = 500000;
    localparam int c_min_gap_cycles = 16;
    localparam int c_cnt_w          = 24;

endpackage
`default_nettype wire

// File: rtl/strip_frame_scheduler_counter.sv
`default_nettype none
// ============================================================================
// Module   : strip_frame_scheduler_counter
// Purpose  : Generic up-counter with synchronous clear and count enable
// Revision : 1.0 - initial release
// ============================================================================
module strip_frame_scheduler_counter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out = r_count;

endmodule
`default_nettype wire

// File: rtl/strip_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : strip_frame_scheduler
// Purpose  : Ping-pong frame bank controller between frame writer and strip engine
// Revision : 1.0 - initial release
// ============================================================================
module strip_frame_scheduler
    import strip_frame_scheduler_pkg::*;
#(
    parameter int REFRESH_CYCLES = c_refresh_cycles,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles,
    parameter int MIN_GAP_CYCLES = c_min_gap_cycles,
    parameter int CNT_W          = c_cnt_w
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        wr_frame_done,
    output logic        wr_ready,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic        rd_start,
    input  logic        rd_done,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    output logic [15:0] frame_cnt
);

    localparam logic [CNT_W-1:0] c_refresh_last = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last     = CNT_W'(MIN_GAP_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_rd_bank;
    logic             r_pending;
    logic             r_shown;
    logic             r_wr_ready;
    logic             r_overrun;
    logic             r_timeout_err;
    logic [15:0]      r_frame_cnt;

    logic [CNT_W-1:0] w_refresh_cnt;
    logic [CNT_W-1:0] w_timeout_cnt;
    logic [CNT_W-1:0] w_gap_cnt;
    logic             w_swap;
    logic             w_refresh_due;
    logic             w_go_start;
    logic             w_in_flight;

    assign w_swap        = (r_state == S_IDLE) && r_pending;
    assign w_refresh_due = r_shown && (w_refresh_cnt >= c_refresh_last);
    assign w_go_start    = (r_state == S_IDLE) && (r_pending || w_refresh_due);
    assign w_in_flight   = (r_state == S_START) || (r_state == S_BUSY);

    // Refresh and timeout are measured from the rd_start cycle, so both clear
    // on the edge that enters S_START.
    strip_frame_scheduler_counter #(.WIDTH(CNT_W)) u_refresh_cnt (
        .clk (sys_clk),
        .rst (rst || w_go_start),
        .en  (w_refresh_cnt != c_refresh_last),
        .out (w_refresh_cnt)
    );

    strip_frame_scheduler_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
        .clk (sys_clk),
        .rst (rst || w_go_start),
        .en  (w_in_flight),
        .out (w_timeout_cnt)
    );

    strip_frame_scheduler_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk (sys_clk),
        .rst (rst || (r_state != S_GAP)),
        .en  (r_state == S_GAP),
        .out (w_gap_cnt)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rd_bank     <= c_rd_bank_rst;
            r_pending     <= 1'b0;
            r_shown       <= 1'b0;
            r_wr_ready    <= 1'b1;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go_start) begin
                        r_state     <= S_START;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        if (r_pending) begin
                            r_rd_bank <= ~r_rd_bank;
                            r_shown   <= 1'b1;
                        end
                    end
                end
                S_START: r_state <= S_BUSY;
                S_BUSY: begin
                    if (rd_done) begin
                        r_state <= S_GAP;
                    end else if (w_timeout_cnt == c_timeout_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_gap_cnt == c_gap_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A frame arriving on the swap cycle still sees pending=1 and overruns.
            if (w_swap) begin
                r_pending  <= 1'b0;
                r_wr_ready <= 1'b1;
            end
            if (wr_frame_done) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending  <= 1'b1;
                    r_wr_ready <= 1'b0;
                end
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign rd_bank     = r_rd_bank;
    assign wr_bank     = ~r_rd_bank;
    assign rd_start    = (r_state == S_START);
    assign busy        = w_in_flight;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_strip_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_strip_frame_scheduler
// Purpose  : Directed vector table plus randomized run against a timestamp model
// Revision : 1.0 - initial release
// ============================================================================
module tb_strip_frame_scheduler;

    localparam int c_refresh = 1000;
    localparam int c_timeout = 300;
    localparam int c_gap     = 16;

    logic        sys_clk;
    logic        rst;
    logic        wr_frame_done;
    logic        rd_done;
    logic        wr_ready;
    logic        wr_bank;
    logic        rd_bank;
    logic        rd_start;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic [15:0] frame_cnt;

    int n_vec;
    int n_bad;

    strip_frame_scheduler #(
        .REFRESH_CYCLES (c_refresh),
        .TIMEOUT_CYCLES (c_timeout),
        .MIN_GAP_CYCLES (c_gap),
        .CNT_W          (24)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .wr_frame_done (wr_frame_done),
        .wr_ready      (wr_ready),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .rd_start      (rd_start),
        .rd_done       (rd_done),
        .busy          (busy),
        .overrun       (overrun),
        .timeout_err   (timeout_err),
        .frame_cnt     (frame_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        rst;
        logic        wfd;
        logic        rdd;
        int          reps;
        logic        st;
        logic        bz;
        logic        wrr;
        logic        rb;
        logic [15:0] fc;
        logic        ov;
        logic        te;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic w, input logic d, input int reps,
                       input logic st, input logic bz, input logic wrr, input logic rb,
                       input int fc, input logic ov, input logic te);
        vec_t v;
        v.rst = r; v.wfd = w; v.rdd = d; v.reps = reps;
        v.st = st; v.bz = bz; v.wrr = wrr; v.rb = rb; v.fc = fc[15:0];
        v.ov = ov; v.te = te;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic r, input logic w, input logic d);
        rst = r; wr_frame_done = w; rd_done = d;
        @(posedge sys_clk);
        #1;
    endtask

    // Expected bundle order: rd_start busy wr_ready wr_bank rd_bank frame_cnt overrun timeout_err
    task automatic check(input string name, input int idx, input logic [22:0] exp_v);
        logic [22:0] act_v;
        act_v = {rd_start, busy, wr_ready, wr_bank, rd_bank, frame_cnt, overrun, timeout_err};
        n_vec++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s #%0d: got st=%b bz=%b wrr=%b wb=%b rb=%b fc=%0d ov=%b te=%b, want st=%b bz=%b wrr=%b wb=%b rb=%b fc=%0d ov=%b te=%b",
                     name, idx, act_v[22], act_v[21], act_v[20], act_v[19], act_v[18], act_v[17:2],
                     act_v[1], act_v[0], exp_v[22], exp_v[21], exp_v[20], exp_v[19], exp_v[18],
                     exp_v[17:2], exp_v[1], exp_v[0]);
        end
    endtask

    // Reference model: tracks when frames started and when the engine becomes
    // free, rather than a state register.
    int          n;
    logic        m_pending, m_shown, m_rd_bank, m_ov, m_te, m_start_now, m_in_busy;
    logic [15:0] m_fc;
    int          m_start_at, m_idle_from;

    task automatic model_step(input logic r, input logic w, input logic d);
        logic nxt_start, swap, old_p;
        nxt_start = 1'b0;
        swap      = 1'b0;
        if (r) begin
            m_pending = 0; m_shown = 0; m_rd_bank = 1; m_ov = 0; m_te = 0;
            m_start_now = 0; m_in_busy = 0; m_fc = 0; m_start_at = 0;
            m_idle_from = n + 1;
        end else begin
            if (m_in_busy) begin
                if (!m_start_now && d) begin
                    m_in_busy = 0; m_idle_from = n + 1 + c_gap;
                end else if (n - m_start_at == c_timeout - 1) begin
                    m_te = 1; m_in_busy = 0; m_idle_from = n + 1 + c_gap;
                end
            end else if (n >= m_idle_from) begin
                if (m_pending) begin
                    swap = 1; nxt_start = 1;
                end else if (m_shown && (n - m_start_at >= c_refresh - 1)) begin
                    nxt_start = 1;
                end
            end
            old_p = m_pending;
            if (swap) begin
                m_pending = 0; m_rd_bank = ~m_rd_bank; m_shown = 1;
            end
            if (w) begin
                if (old_p) m_ov = 1;
                else       m_pending = 1;
            end
            if (nxt_start) begin
                m_in_busy = 1; m_start_at = n + 1; m_fc = m_fc + 16'd1;
            end
            m_start_now = nxt_start;
        end
        n++;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        n = 0;
        rst = 1'b1;
        wr_frame_done = 1'b0;
        rd_done = 1'b0;

        // Reset, idle, first frame, gap with a queued frame and stray rd_done
        add(1,0,0,  1, 0,0,1,1,0,0,0);
        add(0,0,0,100, 0,0,1,1,0,0,0);
        add(0,1,0,  1, 0,0,0,1,0,0,0);
        add(0,0,0,  1, 1,1,1,0,1,0,0);
        add(0,0,0,  1, 0,1,1,0,1,0,0);
        add(0,0,1,  1, 0,0,1,0,1,0,0);
        add(0,0,0,  1, 0,0,1,0,1,0,0);
        add(0,1,0,  1, 0,0,0,0,1,0,0);
        add(0,0,1,  1, 0,0,0,0,1,0,0);
        add(0,0,0, 13, 0,0,0,0,1,0,0);
        add(0,0,0,  1, 1,1,1,1,2,0,0);
        // Hung engine: timeout 300 cycles after rd_start, pending frame follows the gap
        add(0,0,0,100, 0,1,1,1,2,0,0);
        add(0,1,0,  1, 0,1,0,1,2,0,0);
        add(0,0,0,198, 0,1,0,1,2,0,0);
        add(0,0,0,  1, 0,0,0,1,2,0,1);
        add(0,0,0, 16, 0,0,0,1,2,0,1);
        add(0,0,0,  1, 1,1,1,0,3,0,1);
        // Two frames while busy: overrun, one swap after rd_done + gap
        add(0,1,0,  1, 0,1,0,0,3,0,1);
        add(0,1,0,  1, 0,1,0,0,3,1,1);
        add(0,0,0,197, 0,1,0,0,3,1,1);
        add(0,0,1,  1, 0,0,0,0,3,1,1);
        add(0,0,0, 16, 0,0,0,0,3,1,1);
        add(0,0,0,  1, 1,1,1,1,4,1,1);
        // rd_done and wr_frame_done together, then reset inside the gap
        add(0,0,0,  5, 0,1,1,1,4,1,1);
        add(0,1,1,  1, 0,0,0,1,4,1,1);
        add(0,0,0,  5, 0,0,0,1,4,1,1);
        add(1,0,0,  1, 0,0,1,1,0,0,0);
        add(0,0,0, 30, 0,0,1,1,0,0,0);
        // Refresh: one frame shown, re-sent every c_refresh cycles on the same bank
        add(0,1,0,  1, 0,0,0,1,0,0,0);
        add(0,0,0,  1, 1,1,1,0,1,0,0);
        for (int k = 1; k <= 2; k++) begin
            add(0,0,0, 49, 0,1,1,0,k,0,0);
            add(0,0,1,  1, 0,0,1,0,k,0,0);
            add(0,0,0,949, 0,0,1,0,k,0,0);
            add(0,0,0,  1, 1,1,1,0,k+1,0,0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                apply(tbl[i].rst, tbl[i].wfd, tbl[i].rdd);
                check("table", i, {tbl[i].st, tbl[i].bz, tbl[i].wrr, ~tbl[i].rb, tbl[i].rb,
                                   tbl[i].fc, tbl[i].ov, tbl[i].te});
            end
        end

        // Randomized run; epochs alternate busy writers with quiet periods
        begin
            logic r, w, d, quiet, slow_engine;
            quiet = 0;
            slow_engine = 0;
            model_step(1'b1, 1'b0, 1'b0);
            apply(1'b1, 1'b0, 1'b0);
            check("rand", 0, {m_start_now, m_in_busy, ~m_pending, ~m_rd_bank, m_rd_bank,
                              m_fc, m_ov, m_te});
            for (int c = 1; c < 9000; c++) begin
                if (c % 1500 == 0) begin
                    quiet       = 1'($urandom_range(0, 1));
                    slow_engine = 1'($urandom_range(0, 1));
                end
                r = ($urandom_range(0, 2499) == 0);
                w = quiet ? ($urandom_range(0, 2999) == 0) : ($urandom_range(0, 39) == 0);
                d = slow_engine ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 19) == 0);
                model_step(r, w, d);
                apply(r, w, d);
                check("rand", c, {m_start_now, m_in_busy, ~m_pending, ~m_rd_bank, m_rd_bank,
                                  m_fc, m_ov, m_te});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
